// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/CMD/DATA/CHK byte frames from a UART receiver and writes the
// time and display registers; frames stalled longer than TIMEOUT_CLKS are dropped.
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CLKS = 8680
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic [7:0] o_disp_byte,
  output logic       o_set_stb,
  output logic       o_cmd_ok,
  output logic       o_cmd_err,
  output logic       o_busy
);

  localparam int CW = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [CW-1:0] GAP_LAST = CW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] SYNC = 8'h55;

  typedef enum logic [1:0] {IDLE, GET_CMD, GET_DATA, GET_CHK} state_t;

  state_t        state;
  logic [7:0]    cmd_q;
  logic [7:0]    data_q;
  logic [CW-1:0] gap_cnt;
  logic          frame_ok;
  logic          timeout;

  function automatic logic data_in_range(input logic [7:0] cmd, input logic [7:0] data);
    case (cmd)
      8'h01:   return data < 8'd24;
      8'h02,
      8'h03:   return data < 8'd60;
      8'h04:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Current byte is the CHK byte when evaluated in GET_CHK.
  assign frame_ok = (i_rx_byte == (cmd_q ^ data_q)) && data_in_range(cmd_q, data_q);
  assign timeout  = !i_rx_dv && (state != IDLE) && (gap_cnt == GAP_LAST);
  assign o_busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_q       <= '0;
      data_q      <= '0;
      gap_cnt     <= '0;
      o_hours     <= '0;
      o_minutes   <= '0;
      o_seconds   <= '0;
      o_disp_byte <= '0;
      o_set_stb   <= 1'b0;
      o_cmd_ok    <= 1'b0;
      o_cmd_err   <= 1'b0;
    end else begin
      o_set_stb <= 1'b0;
      o_cmd_ok  <= 1'b0;
      o_cmd_err <= 1'b0;

      if (i_rx_dv || state == IDLE)
        gap_cnt <= '0;
      else if (gap_cnt != '1)
        gap_cnt <= gap_cnt + CW'(1);

      // A byte arriving on the timeout cycle takes priority over the timeout.
      if (i_rx_dv) begin
        unique case (state)
          IDLE: begin
            if (i_rx_byte == SYNC)
              state <= GET_CMD;
          end
          GET_CMD: begin
            cmd_q <= i_rx_byte;
            state <= GET_DATA;
          end
          GET_DATA: begin
            data_q <= i_rx_byte;
            state  <= GET_CHK;
          end
          GET_CHK: begin
            state <= IDLE;
            if (frame_ok) begin
              o_set_stb <= 1'b1;
              o_cmd_ok  <= 1'b1;
              case (cmd_q)
                8'h01:   o_hours     <= data_q[4:0];
                8'h02:   o_minutes   <= data_q[5:0];
                8'h03:   o_seconds   <= data_q[5:0];
                default: o_disp_byte <= data_q;
              endcase
            end else begin
              o_cmd_err <= 1'b1;
            end
          end
        endcase
      end else if (timeout) begin
        state     <= IDLE;
        o_cmd_err <= 1'b1;
      end
    end
  end

endmodule
